// File: rtl/car_bus_sequencer.sv
// car_bus_sequencer: arbitrates CAR address requests onto the Addr bus,
// applies the requester's post-inc/dec, and performs Xbus register copies.
// Optional build macro CAR_SEQ_FIXED_PRIO_EN selects fixed priority
// (pcra0 highest) instead of round-robin arbitration.
// Every output is a register loaded from the next-state decode, so the
// strobes for a state are visible exactly while that state is held.
module car_bus_sequencer #(
  parameter int ADDR_HOLD = 1
) (
  input  logic       clock_i,
  input  logic       clear_i,
  input  logic [4:0] req_i,
  input  logic [9:0] op_i,
  input  logic       xfer_req_i,
  input  logic [2:0] xfer_src_i,
  input  logic [2:0] xfer_dst_i,
  output logic       xfer_ack_o,
  output logic [4:0] gnt_o,
  output logic [4:0] addr_assert_n_o,
  output logic [4:0] xbus_assert_n_o,
  output logic [4:0] xbus_load_n_o,
  output logic [4:0] inc_o,
  output logic [4:0] dec_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, ADDR, POST, XFER} state_e;

  localparam logic [1:0] HOLD_M1 = 2'(ADDR_HOLD - 1);
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  state_e     state_q, state_d;
  logic [2:0] gidx_q, gidx_d;
  logic [1:0] op_q, op_d;
  logic [1:0] cnt_q, cnt_d;

  logic       ack_d, busy_d;
  logic [4:0] gnt_d, an_d, xa_d, xl_d, inc_d, dec_d;
  logic [4:0] gsel;
  logic [2:0] pick;
  logic       found;
  logic       xfer_ok;

`ifndef CAR_SEQ_FIXED_PRIO_EN
  logic [2:0] ptr_q, ptr_d;
  int         idx;

  // Round-robin pick: first requester at or after the pointer, wrapping 4->0.
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < 5; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= 5) idx = idx - 5;
      if (!found && req_i[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
  end
`else
  // Fixed-priority pick: lowest index wins.
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!found && req_i[k]) begin
        pick  = 3'(k);
        found = 1'b1;
      end
    end
  end
`endif

  assign xfer_ok = (xfer_src_i != xfer_dst_i) && (xfer_src_i <= 3'd4) && (xfer_dst_i <= 3'd4);

  // Next-state decode plus the output values that the next state implies.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
`ifndef CAR_SEQ_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    ack_d   = 1'b0;
    xa_d    = 5'h1F;
    xl_d    = 5'h1F;
    case (state_q)
      IDLE: begin
        if (xfer_req_i) begin
          state_d = XFER;
          ack_d   = 1'b1;
          if (xfer_ok) begin
            xa_d = ~(5'b00001 << xfer_src_i);
            xl_d = ~(5'b00001 << xfer_dst_i);
          end
        end else if (found) begin
          state_d = ADDR;
          gidx_d  = pick;
          op_d    = 2'(op_i >> {pick, 1'b0});
          cnt_d   = HOLD_M1;
`ifndef CAR_SEQ_FIXED_PRIO_EN
          ptr_d   = (pick == 3'd4) ? 3'd0 : pick + 3'd1;
`endif
        end
      end
      ADDR: begin
        if (cnt_q == 2'd0)
          state_d = (op_q == OP_INC || op_q == OP_DEC) ? POST : IDLE;
        else
          cnt_d = cnt_q - 2'd1;
      end
      POST:    state_d = IDLE;
      XFER:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    gsel   = 5'b00001 << gidx_d;
    gnt_d  = (state_d == ADDR || state_d == POST) ? gsel : 5'h00;
    an_d   = (state_d == ADDR) ? ~gsel : 5'h1F;
    inc_d  = (state_d == POST && op_d == OP_INC) ? gsel : 5'h00;
    dec_d  = (state_d == POST && op_d == OP_DEC) ? gsel : 5'h00;
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; clear drops any operation in flight.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q         <= IDLE;
      gidx_q          <= 3'd0;
      op_q            <= 2'b00;
      cnt_q           <= 2'd0;
`ifndef CAR_SEQ_FIXED_PRIO_EN
      ptr_q           <= 3'd0;
`endif
      xfer_ack_o      <= 1'b0;
      gnt_o           <= 5'h00;
      addr_assert_n_o <= 5'h1F;
      xbus_assert_n_o <= 5'h1F;
      xbus_load_n_o   <= 5'h1F;
      inc_o           <= 5'h00;
      dec_o           <= 5'h00;
      busy_o          <= 1'b0;
    end else begin
      state_q         <= state_d;
      gidx_q          <= gidx_d;
      op_q            <= op_d;
      cnt_q           <= cnt_d;
`ifndef CAR_SEQ_FIXED_PRIO_EN
      ptr_q           <= ptr_d;
`endif
      xfer_ack_o      <= ack_d;
      gnt_o           <= gnt_d;
      addr_assert_n_o <= an_d;
      xbus_assert_n_o <= xa_d;
      xbus_load_n_o   <= xl_d;
      inc_o           <= inc_d;
      dec_o           <= dec_d;
      busy_o          <= busy_d;
    end
  end

endmodule

// File: doc/car_bus_sequencer.md
CAR_BUS_SEQUENCER -- requirements
Module: car_bus_sequencer

Interface
REQ-001 Parameter ADDR_HOLD, default 1, cycles the granted register drives Addr; legal range 1..4.
REQ-002 clock  in  1  single clock; all state changes on rising edge.
REQ-003 clear  in  1  reset, synchronous, active-high.
REQ-004 req  in  5  address requests, bit 0=pcra0, 1=pcra1, 2=sp, 3=si, 4=di; same bit order for every 5-bit port.
REQ-005 op  in  10  post-op per requester, bits [2i+1:2i]: 00 none, 01 post-inc, 10 post-dec, 11 treated as none.
REQ-006 xfer_req  in  1  register-to-register copy over Xbus requested.
REQ-007 xfer_src, xfer_dst  in  3 each  source/destination register index 0..4.
REQ-008 xfer_ack  out  1  one-cycle pulse when a transfer request is consumed.
REQ-009 gnt  out  5  one-hot grant, high in every ADDR and POST cycle of the granted requester.
REQ-010 addr_assert_n, xbus_assert_n, xbus_load_n  out  5 each  active-low CAR strobes.
REQ-011 inc, dec  out  5 each  active-high CAR count strobes.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ADDR, POST, XFER.
REQ-014 In IDLE with xfer_req high, the FSM SHALL go to XFER; xfer_req has priority over req.
REQ-015 In IDLE with xfer_req low and req nonzero, the FSM SHALL grant one requester, latch its op and go to ADDR.
REQ-016 In ADDR, addr_assert_n SHALL be low for the granted bit only, for exactly ADDR_HOLD cycles.
REQ-017 After ADDR, latched op 01 or 10 SHALL cause one POST cycle with inc or dec high for the granted bit only. Otherwise the FSM SHALL return to IDLE directly.
REQ-018 POST SHALL always return to IDLE, so back-to-back grants are separated by at least one IDLE cycle.
REQ-019 Deasserting req or changing op after grant SHALL NOT abort or alter the operation in progress.
REQ-020 XFER SHALL last one cycle: xbus_assert_n[src] low, xbus_load_n[dst] low, xfer_ack high, then IDLE.
REQ-021 If xfer_src equals xfer_dst, or either index exceeds 4, XFER SHALL pulse xfer_ack with all strobes inactive.
REQ-022 At most one bit of addr_assert_n and one bit of xbus_assert_n SHALL be low in any cycle; inc and dec SHALL never both be high.
REQ-023 Round-robin: after a grant to i, the search SHALL start at (i+1) mod 5; a pointer wrap 4->0 SHALL be seamless.
REQ-024 All outputs SHALL be registered; the grant decision appears on outputs the cycle after IDLE samples req.

Reset
REQ-025 clear high at a clock edge SHALL force IDLE, gnt=0, inc=0, dec=0, xfer_ack=0, busy=0, all *_n outputs=5'h1F, and round-robin search start=pcra0.
REQ-026 clear mid-ADDR, mid-POST or mid-XFER SHALL drop the operation without emitting any pending inc/dec/load strobe.

Configuration
REQ-027 Macro CAR_SEQ_FIXED_PRIO_EN defined: arbitration SHALL be fixed priority, pcra0 highest and di lowest, and the round-robin pointer SHALL be absent.
REQ-028 Macro CAR_SEQ_FIXED_PRIO_EN undefined: arbitration SHALL be round-robin per REQ-023.

Verification
REQ-029 After clear, req=5'h1F held, all op=00, ADDR_HOLD=1 -> grants in order pcra0, pcra1, sp, si, di, pcra0, each with one addr_assert_n low cycle (fixed-prio build: pcra0 every time).
REQ-030 req[2]=1, op[5:4]=01, ADDR_HOLD=3 -> addr_assert_n=5'h1B for 3 cycles, then inc=5'h04 for one cycle, then IDLE.
REQ-031 xfer_req=1 and req=5'h01 in the same IDLE cycle, src=3, dst=1 -> XFER first: xbus_assert_n=5'h17, xbus_load_n=5'h1D, xfer_ack=1; pcra0 is granted afterwards.
REQ-032 xfer_src=2, xfer_dst=2 -> xfer_ack pulses once, all *_n outputs stay 5'h1F.
REQ-033 req[4]=1, op=10, clear asserted on the second ADDR cycle with ADDR_HOLD=2 -> dec stays 0, outputs at reset values next cycle.
REQ-034 Random req/op/xfer for 10k cycles -> REQ-022 invariants never violated, and no requester starves beyond 5 grants (round-robin build).
